// File: rtl/mbist_pkg.sv
// Shared March C- definitions: controller states and the per-element operation tables.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M0    = 3'd1,
        ST_M1    = 3'd2,
        ST_M2    = 3'd3,
        ST_M3    = 3'd4,
        ST_M4    = 3'd5,
        ST_M5    = 3'd6,
        ST_DRAIN = 3'd7
    } state_t;

    localparam int N_ELEM      = 6;
    localparam int FAIL_ELEM_W = 3;

    // Tables indexed by element number 0..5; bits 6 and 7 are padding.
    localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
    localparam logic [7:0] ELEM_RD     = 8'b0011_1110;
    localparam logic [7:0] ELEM_WR     = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_EXP = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_VAL = 8'b0000_1010;

    function automatic logic [FAIL_ELEM_W-1:0] elem_of(state_t s);
        return FAIL_ELEM_W'(s - 3'd1);
    endfunction

endpackage

// File: rtl/mbist_addr_cnt.sv
// Up/down address counter with load-to-0, load-to-max, enable and a direction-aware terminal count.
module mbist_addr_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_zero_i,
    input  logic         ld_max_i,
    input  logic         en_i,
    input  logic         up_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_zero_i) begin
            cnt_d = '0;
        end else if (ld_max_i) begin
            cnt_d = '1;
        end else if (en_i) begin
            cnt_d = up_i ? cnt_q + W'(1) : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = up_i ? (cnt_q == '1) : (cnt_q == '0);

endmodule

// File: rtl/march_cm_ctrl.sv
// March C- memory test controller; define MCM_FAIL_LOG_EN to add first-failure address/element capture.
// state | meaning: IDLE wait start | M0..M5 march elements (phase 0 read, 1 write in M1-M4) | DRAIN last compare
module march_cm_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   fail
`ifdef MCM_FAIL_LOG_EN
    ,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [FAIL_ELEM_W-1:0] fail_elem
`endif
);

    state_t state_q, state_d;
    logic phase_q, phase_d;
    logic done_q, done_d;
    logic fail_q;
    logic pend_q, exp_q;
    logic [FAIL_ELEM_W-1:0] elem;
    logic cnt_ld0, cnt_ldmax, cnt_en, cnt_up, cnt_tc;
    logic [ADDR_W-1:0] cnt;
    logic we, re, wval, rd_exp, start_acc, mismatch;

    mbist_addr_cnt #(.W(ADDR_W)) u_addr_cnt (
        .clk_i     (clk),
        .rst_i     (rst),
        .ld_zero_i (cnt_ld0),
        .ld_max_i  (cnt_ldmax),
        .en_i      (cnt_en),
        .up_i      (cnt_up),
        .cnt_o     (cnt),
        .tc_o      (cnt_tc)
    );

    assign elem      = elem_of(state_q);
    assign start_acc = (state_q == ST_IDLE) && start;
    assign mismatch  = pend_q && (mem_rdata != {DATA_W{exp_q}});

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        done_d    = done_q;
        cnt_ld0   = 1'b0;
        cnt_ldmax = 1'b0;
        cnt_en    = 1'b0;
        cnt_up    = ~ELEM_DOWN[elem];
        we        = 1'b0;
        re        = 1'b0;
        wval      = 1'b0;
        rd_exp    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_M0;
                    phase_d = 1'b0;
                    done_d  = 1'b0;
                    cnt_ld0 = 1'b1;
                end
            end
            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                if (ELEM_RD[elem] && ELEM_WR[elem] && !phase_q) begin
                    re      = 1'b1;
                    rd_exp  = ELEM_RD_EXP[elem];
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (ELEM_WR[elem]) begin
                        we   = 1'b1;
                        wval = ELEM_WR_VAL[elem];
                    end else begin
                        re     = 1'b1;
                        rd_exp = ELEM_RD_EXP[elem];
                    end
                    // Last op at this address: advance, or hand over to the next element.
                    if (!cnt_tc) begin
                        cnt_en = 1'b1;
                    end else if (elem == FAIL_ELEM_W'(N_ELEM - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = state_t'(state_q + 3'd1);
                        if (ELEM_DOWN[elem + 3'd1]) begin
                            cnt_ldmax = 1'b1;
                        end else begin
                            cnt_ld0 = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            pend_q  <= re;
            exp_q   <= rd_exp;
        end
    end

`ifdef MCM_FAIL_LOG_EN
    logic [ADDR_W-1:0]      pend_addr_q, fail_addr_q;
    logic [FAIL_ELEM_W-1:0] pend_elem_q, fail_elem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_elem_q <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            pend_addr_q <= cnt;
            pend_elem_q <= elem;
            if (start_acc) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= '0;
            end else if (mismatch && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= pend_addr_q;
                fail_elem_q <= pend_elem_q;
            end
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q <= 1'b0;
        end else if (start_acc) begin
            fail_q <= 1'b0;
        end else if (mismatch) begin
            fail_q <= 1'b1;
        end
    end
`endif

    assign mem_addr  = cnt;
    assign mem_we    = we;
    assign mem_re    = re;
    assign mem_wdata = {DATA_W{wval}};
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_march_cm_ctrl.sv
// Directed bench for march_cm_ctrl: an ADDR_W=2 instance for cycle-exact checks and an ADDR_W=1 instance.
module tb_march_cm_ctrl;

    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int NOPS = 10 * N;
    localparam int AWS  = 1;
    localparam int NS   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, done, fail;

    logic           start_s;
    logic [AWS-1:0] mem_addr_s;
    logic           mem_we_s, mem_re_s;
    logic [DW-1:0]  mem_wdata_s, mem_rdata_s;
    logic           busy_s, done_s, fail_s;

`ifdef MCM_FAIL_LOG_EN
    logic [AW-1:0]  fail_addr;
    logic [2:0]     fail_elem;
    logic [AWS-1:0] fail_addr_s;
    logic [2:0]     fail_elem_s;
`endif

    int checks   = 0;
    int failures = 0;
    int overlap   = 0;
    int overlap_s = 0;
    bit fault_en  = 1'b0;

    logic [DW-1:0] mem   [N];
    logic [DW-1:0] mem_s [NS];

    logic          exp_we   [NOPS];
    logic          exp_re   [NOPS];
    logic [AW-1:0] exp_addr [NOPS];
    logic [DW-1:0] exp_wd   [NOPS];

    march_cm_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail)
`ifdef MCM_FAIL_LOG_EN
        ,
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
`endif
    );

    march_cm_ctrl #(.ADDR_W(AWS), .DATA_W(DW)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .mem_addr  (mem_addr_s),
        .mem_we    (mem_we_s),
        .mem_re    (mem_re_s),
        .mem_wdata (mem_wdata_s),
        .mem_rdata (mem_rdata_s),
        .busy      (busy_s),
        .done      (done_s),
        .fail      (fail_s)
`ifdef MCM_FAIL_LOG_EN
        ,
        .fail_addr (fail_addr_s),
        .fail_elem (fail_elem_s)
`endif
    );

    // Synchronous memories; the optional fault forces bit 0 of address 2 to read as 1.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr] | ((fault_en && mem_addr == 2'd2) ? 8'h01 : 8'h00);
        if (mem_we_s) mem_s[mem_addr_s] <= mem_wdata_s;
        if (mem_re_s) mem_rdata_s <= mem_s[mem_addr_s];
    end

    always @(negedge clk) begin
        if (mem_we && mem_re) overlap++;
        if (mem_we_s && mem_re_s) overlap_s++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic set_op(input int k, input logic w, input logic r, input int a, input logic one);
        exp_we[k]   = w;
        exp_re[k]   = r;
        exp_addr[k] = AW'(a);
        exp_wd[k]   = {DW{one}};
    endtask

    // March C- op list written out element by element.
    task automatic build_expected();
        int k;
        k = 0;
        for (int a = 0; a < N; a++) begin set_op(k, 1, 0, a, 0); k++; end
        for (int a = 0; a < N; a++) begin set_op(k, 0, 1, a, 0); k++; set_op(k, 1, 0, a, 1); k++; end
        for (int a = 0; a < N; a++) begin set_op(k, 0, 1, a, 0); k++; set_op(k, 1, 0, a, 0); k++; end
        for (int a = N - 1; a >= 0; a--) begin set_op(k, 0, 1, a, 0); k++; set_op(k, 1, 0, a, 1); k++; end
        for (int a = N - 1; a >= 0; a--) begin set_op(k, 0, 1, a, 0); k++; set_op(k, 1, 0, a, 0); k++; end
        for (int a = 0; a < N; a++) begin set_op(k, 0, 1, a, 0); k++; end
    endtask

    // Starts a run from IDLE at a falling edge and checks every cycle through the done cycle.
    // With fault set, the M1 read of address 2 happens in cycle 9 and fail shows from cycle 11.
    task automatic run_march(input string tag, input bit fault, input int poke);
        int  i;
        logic exp_busy, exp_done, exp_fail;
        fault_en = fault;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= NOPS + 2; k++) begin
            @(negedge clk);
            if (k == poke + 1) start = 1'b0;
            if (k <= NOPS) begin
                i = k - 1;
                checks++;
                if ({mem_we, mem_re, mem_addr} !== {exp_we[i], exp_re[i], exp_addr[i]}) begin
                    failures++;
                    $display("FAIL %s op cycle=%0d got we/re/addr=%b/%b/%0d want %b/%b/%0d",
                             tag, k, mem_we, mem_re, mem_addr, exp_we[i], exp_re[i], exp_addr[i]);
                end
                if (exp_we[i]) begin
                    checks++;
                    if (mem_wdata !== exp_wd[i]) begin
                        failures++;
                        $display("FAIL %s wdata cycle=%0d got %h want %h", tag, k, mem_wdata, exp_wd[i]);
                    end
                end
            end else begin
                checks++;
                if ({mem_we, mem_re} !== 2'b00) begin
                    failures++;
                    $display("FAIL %s idle_strobes cycle=%0d got we/re=%b/%b want 0/0", tag, k, mem_we, mem_re);
                end
            end
            exp_busy = (k <= NOPS + 1);
            exp_done = (k == NOPS + 2);
            exp_fail = fault && (k >= 11);
            checks++;
            if ({busy, done, fail} !== {exp_busy, exp_done, exp_fail}) begin
                failures++;
                $display("FAIL %s flags cycle=%0d got busy/done/fail=%b/%b/%b want %b/%b/%b",
                         tag, k, busy, done, fail, exp_busy, exp_done, exp_fail);
            end
            if (k == poke) start = 1'b1;
        end
`ifdef MCM_FAIL_LOG_EN
        checks++;
        if ({fail_addr, fail_elem} !== (fault ? {2'd2, 3'd1} : {2'd0, 3'd0})) begin
            failures++;
            $display("FAIL %s fail_log got addr/elem=%0d/%0d want %0d/%0d",
                     tag, fail_addr, fail_elem, fault ? 2 : 0, fault ? 1 : 0);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, mem_addr, mem_wdata, busy, done, fail} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we/re/addr/wdata/busy/done/fail=%b/%b/%0d/%h/%b/%b/%b want all 0",
                     mem_we, mem_re, mem_addr, mem_wdata, busy, done, fail);
        end
        checks++;
        if ({mem_we_s, mem_re_s, mem_addr_s, mem_wdata_s, busy_s, done_s, fail_s} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_small got we/re/addr/wdata/busy/done/fail=%b/%b/%0d/%h/%b/%b/%b want all 0",
                     mem_we_s, mem_re_s, mem_addr_s, mem_wdata_s, busy_s, done_s, fail_s);
        end
`ifdef MCM_FAIL_LOG_EN
        checks++;
        if ({fail_addr, fail_elem} !== '0) begin
            failures++;
            $display("FAIL reset_fail_log got %0d/%0d want 0/0", fail_addr, fail_elem);
        end
`endif
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, mem_we} !== 2'b00) begin
            failures++;
            $display("FAIL rst_priority got busy/we=%b/%b want 0/0", busy, mem_we);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_priority_after got busy=%b want 0", busy);
        end
    endtask

    task automatic test_good();
        run_march("good", 1'b0, 0);
    endtask

    task automatic test_stuck_at();
        run_march("stuck_at", 1'b1, 0);
    endtask

    task automatic test_restart_ignored();
        run_march("restart", 1'b0, 10);
    endtask

    task automatic test_abort_in_m3();
        fault_en = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (23) @(negedge clk);
        checks++;
        if ({mem_re, mem_addr} !== {1'b1, 2'd2}) begin
            failures++;
            $display("FAIL abort_m3_read got re/addr=%b/%0d want 1/2", mem_re, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, mem_addr, mem_wdata, busy, done, fail} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got we/re/addr/wdata/busy/done/fail=%b/%b/%0d/%h/%b/%b/%b want all 0",
                     mem_we, mem_re, mem_addr, mem_wdata, busy, done, fail);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, fail, mem_re} !== 3'b000) begin
            failures++;
            $display("FAIL abort_no_pending got busy/fail/re=%b/%b/%b want 0/0/0", busy, fail, mem_re);
        end
        run_march("after_abort", 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_march("b2b_first", 1'b1, 0);
        run_march("b2b_second", 1'b0, 0);
    endtask

    task automatic test_small();
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = 0;
        start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(negedge clk);
            if (busy_s) busy_cnt++;
            if (done_s) done_at = k;
        end
        checks++;
        if (done_at != 22) begin
            failures++;
            $display("FAIL small_done_edge got %0d want 22", done_at);
        end
        checks++;
        if (busy_cnt != 21) begin
            failures++;
            $display("FAIL small_busy_cycles got %0d want 21", busy_cnt);
        end
        checks++;
        if (fail_s !== 1'b0) begin
            failures++;
            $display("FAIL small_fail got %b want 0", fail_s);
        end
        checks++;
        if (overlap_s != 0 || overlap != 0) begin
            failures++;
            $display("FAIL strobe_overlap got small/main=%0d/%0d want 0/0", overlap_s, overlap);
        end
    endtask

    initial begin
        build_expected();
        test_reset();
        test_good();
        test_stuck_at();
        test_restart_ignored();
        test_abort_in_m3();
        test_back_to_back();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/march_cm_ctrl.md
MARCH_CM_CTRL -- requirements
Module: march_cm_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: memory address width, legal range 1..12; N = 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8: memory word width; the data backgrounds are all-0 and all-1.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: starts a test when sampled high in IDLE.
REQ-006 SHALL have port mem_addr, output, ADDR_W: memory address.
REQ-007 SHALL have ports mem_we and mem_re, both output, 1: write strobe and read strobe; at most one is high in any cycle.
REQ-008 SHALL have port mem_wdata, output, DATA_W: write data.
REQ-009 SHALL have port mem_rdata, input, DATA_W: read data, valid the cycle after mem_re.
REQ-010 SHALL have port busy, output, 1: high from the cycle after start is accepted until done rises.
REQ-011 SHALL have ports done and fail, both output, 1: completion flag and sticky mismatch flag.
REQ-012 SHALL have ports fail_addr (output, ADDR_W) and fail_elem (output, 3), present only with MCM_FAIL_LOG_EN.

Function
REQ-013 SHALL run March C- as six elements. M0: up, w0. M1: up, r0 then w1. M2: up, r1 then w0. M3: down, r0 then w1. M4: down, r1 then w0. M5: up, r0.
REQ-014 SHALL use states IDLE, M0, M1, M2, M3, M4, M5 and DRAIN; a phase bit selects the read or write op within M1-M4.
REQ-015 SHALL issue one op per cycle. Each M1-M4 address takes 2 cycles (read, then write at the same address); each M0/M5 address takes 1 cycle.
REQ-016 SHALL walk up elements from address 0 to N-1 and down elements from N-1 to 0. The next element starts on the cycle after the terminal address's last op, with no idle cycle between elements.
REQ-017 SHALL drive mem_wdata as {DATA_W{1'b0}} for w0 and {DATA_W{1'b1}} for w1; mem_wdata is don't-care while mem_we is low.
REQ-018 SHALL register the expected value and a valid bit with each read, and compare mem_rdata one cycle later.
REQ-019 SHALL set fail on any mismatch; fail stays high until the next accepted start or rst.
REQ-020 SHALL enter DRAIN for 1 cycle after the last M5 read to complete its compare, then return to IDLE with done=1 and busy=0.
REQ-021 SHALL hold busy high for exactly 10N+1 cycles, so done rises 10N+2 edges after the edge that samples start.
REQ-022 SHALL, on start in IDLE, clear done and fail on the same edge and enter M0.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL hold done high in IDLE until the next accepted start.
REQ-025 SHALL keep mem_we=0 and mem_re=0 in IDLE and DRAIN.
REQ-026 SHALL support N=2 (ADDR_W=1); in that case each element takes exactly 2 or 4 cycles.
REQ-027 SHALL recover to IDLE from any unused state encoding on the next edge.

Reset
REQ-028 SHALL apply, on rst high at a clock edge, state=IDLE, mem_addr=0, mem_we=0, mem_re=0, mem_wdata=0, busy=0, done=0 and fail=0, plus fail_addr=0 and fail_elem=0 when present.
REQ-029 SHALL let rst abort a test at any point, with strobes low from the next cycle onward and no pending compare retained.
REQ-030 SHALL give rst priority over start on the same edge.

Configuration
REQ-031 SHALL, with MCM_FAIL_LOG_EN defined, capture the address and element number (0-5) of the first mismatch only into fail_addr and fail_elem, held until start or rst.
REQ-032 SHALL, without MCM_FAIL_LOG_EN, omit the fail_addr and fail_elem ports and their registers; all other behaviour is identical.

Structure
REQ-033 SHALL place in shared package mbist_pkg: the state typedef, element count 6, the per-element direction, read-expect and write-value table, and the fail_elem width constant.
REQ-034 SHALL use sub-module mbist_addr_cnt: an up/down address counter with load-to-0, load-to-max, enable and a terminal-count flag.

Verification
REQ-035 SHALL cover a good memory with ADDR_W=2: start pulse, then busy for 41 cycles, done=1, fail=0; address sequence 0..3 ×2 in M0-M2, 3..0 in M3/M4, 0..3 in M5.
REQ-036 SHALL cover a stuck-at-1 bit 0 at address 2: fail rises on the edge after the M1 r0 of address 2; fail_addr=2 and fail_elem=1; done still rises at cycle 42.
REQ-037 SHALL cover start re-asserted at cycle 10 of a run: it is ignored, with timing identical to the first scenario.
REQ-038 SHALL cover rst asserted during M3: all outputs are 0 the next cycle; a following start runs a full clean test.
REQ-039 SHALL cover back-to-back tests: start the cycle after done; done and fail clear on that edge and the second run matches the first scenario.
REQ-040 SHALL cover ADDR_W=1: done rises 22 edges after start, and mem_we and mem_re are never high together.
